sys_act_feeder: RTL

// Transmit side of the systolic array activation interface: buffers activation vectors from the

---
 rtl/sys_act_feeder_pkg.sv | 26 ++
 rtl/sys_vec_fifo.sv | 57 +++++
 rtl/sys_act_feeder.sv | 109 ++++++++++
 3 files changed

// File: rtl/sys_act_feeder_pkg.sv
// Shared configuration for the systolic array activation feeder: array
// geometry, activation vector type and the feeder's fixed issue latency.
package sys_act_feeder_pkg;

    localparam int sys_rows   = 4;
    localparam int sys_cols   = 2;
    localparam int A_BITWIDTH = 8;

    // Cycles from a FIFO pop to the issue register driving row 0.
    localparam int FEED_LAT = 1;

    typedef logic [sys_rows-1:0][A_BITWIDTH-1:0] act_vec_t;

    // One buffered entry: the vector plus its end-of-tile flag.
    typedef struct packed {
        logic     last;
        act_vec_t data;
    } fifo_entry_t;

    // Cycles from pop until column col's result leaves the bottom of the array:
    // issue register, then sys_rows mac stages down plus col A hops across.
    function automatic int marker_delay(input int col, input int mac_lat);
        return FEED_LAT + (sys_rows + col) * mac_lat;
    endfunction

endpackage

// File: rtl/sys_vec_fifo.sv
// Synchronous FIFO with valid/ready on both sides. Ready on the push side is
// derived only from the registered occupancy, so a pop in the same cycle
// never frees a slot for a push into a full buffer.
module sys_vec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push;
    logic             pop;

    assign push_ready = (count != (AW+1)'(DEPTH));
    assign pop_valid  = (count != '0);
    assign push       = push_valid && push_ready;
    assign pop        = pop_ready && pop_valid;
    assign pop_data   = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy is, and unoccupied entries are never read as valid.
        if (rst && push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sys_act_feeder.sv
// Activation feeder for the systolic array: buffers loader vectors, issues
// one slot (vector or bubble) per cycle, skews row r by r cycles and emits
// per-column result-valid markers plus an end-of-tile pulse.
module sys_act_feeder
    import sys_act_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAC_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  act_vec_t            s_data,
    input  logic                s_last,
    input  logic                w_busy,
    output logic [sys_rows-1:0] if_en,
    output act_vec_t            if_data,
    output logic [sys_cols-1:0] of_valid,
    output logic                busy,
    output logic                tile_done
);

    // Marker chain length covers the last column's result; stage 0 is the issue register.
    localparam int MK_LEN = marker_delay(sys_cols - 1, MAC_LAT);

    fifo_entry_t         push_entry;
    fifo_entry_t         pop_entry;
    logic                fifo_ready;
    logic                fifo_valid;
    logic                pop;
    logic [MK_LEN-1:0]   mk_en;
    logic [MK_LEN-1:0]   mk_last;
    act_vec_t            iss_data;
    logic [sys_rows-1:0] row_en;
    act_vec_t            row_data;
    logic [sys_rows-1:0] row_busy;

    assign push_entry = '{last: s_last, data: s_data};
    assign s_ready    = rst && fifo_ready;
    assign pop        = fifo_valid && !w_busy;

    sys_vec_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (s_valid),
        .push_ready (fifo_ready),
        .push_data  (push_entry),
        .pop_valid  (fifo_valid),
        .pop_ready  (pop),
        .pop_data   (pop_entry)
    );

    // Issue register and marker chain: one slot enters every cycle, bubbles carry zero data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mk_en    <= '0;
            mk_last  <= '0;
            iss_data <= '0;
        end else begin
            mk_en    <= {mk_en[MK_LEN-2:0], pop};
            mk_last  <= {mk_last[MK_LEN-2:0], pop && pop_entry.last};
            iss_data <= pop ? pop_entry.data : '0;
        end
    end

    for (genvar r = 0; r < sys_rows; r++) begin : g_skew
        if (r == 0) begin : g_row0
            assign row_en[0]   = mk_en[0];
            assign row_data[0] = iss_data[0];
            assign row_busy[0] = mk_en[0];
        end else begin : g_rowr
            logic [r-1:0]                 en_sr;
            logic [r-1:0][A_BITWIDTH-1:0] data_sr;

            // Row r delay line: r extra stages behind the issue register.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    en_sr   <= '0;
                    data_sr <= '0;
                end else begin
                    en_sr[0]   <= mk_en[0];
                    data_sr[0] <= iss_data[r];
                    for (int k = 1; k < r; k++) begin
                        en_sr[k]   <= en_sr[k-1];
                        data_sr[k] <= data_sr[k-1];
                    end
                end
            end

            assign row_en[r]   = en_sr[r-1];
            assign row_data[r] = data_sr[r-1];
            assign row_busy[r] = |en_sr;
        end
        assign if_en[r]   = row_en[r];
        assign if_data[r] = row_en[r] ? row_data[r] : '0;
    end

    for (genvar c = 0; c < sys_cols; c++) begin : g_marker
        assign of_valid[c] = mk_en[marker_delay(c, MAC_LAT) - 1];
    end

    assign tile_done = mk_en[MK_LEN-1] && mk_last[MK_LEN-1];
    assign busy      = fifo_valid || (|mk_en) || (|row_busy);

endmodule
